// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: in-order instruction queue between fetch and decode.
// Fetch writes up to PUSH_WIDTH entries per cycle. Decode sees up to
// POP_WIDTH of the oldest entries at once and consumes a prefix of them.
// Optional feature macro: FETCH_DECODE_QUEUE_CHECK_EN. When it is defined,
// illegal push/pop requests are dropped and a sticky error flag is raised.

`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 2
`endif

package fetch_decode_pkg;
  // One fetched instruction as handed to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_decode_pack_t;
endpackage

module fetch_decode_queue
  import fetch_decode_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PUSH_WIDTH = `FETCH_WIDTH,
  parameter int POP_WIDTH  = `DECODE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic [PUSH_WIDTH-1:0]               fetch_decode_fifo_data_in_enable,
  input  fetch_decode_pack_t [0:PUSH_WIDTH-1] fetch_decode_fifo_data_in,
  input  logic [PUSH_WIDTH-1:0]               fetch_decode_fifo_data_in_valid,
  input  logic                                fetch_decode_fifo_push,
  input  logic                                fetch_decode_fifo_flush,
  output fetch_decode_pack_t [0:POP_WIDTH-1]  fetch_decode_fifo_data_out,
  output logic [POP_WIDTH-1:0]                fetch_decode_fifo_data_out_valid,
  input  logic [POP_WIDTH-1:0]                fetch_decode_fifo_pop,
  output logic                                fetch_decode_fifo_full,
  output logic                                fetch_decode_fifo_error
);

  // Pointers carry one extra bit so that full and empty are distinguishable
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  fetch_decode_pack_t r_mem [DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;

  logic [PW-1:0]      w_count;
  logic [PW-1:0]      w_free;
  logic [PW-1:0]      w_push_cnt;
  logic [PW-1:0]      w_pop_cnt;
  logic               w_push_req;
  logic               w_pop_req;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic [AW-1:0]      w_waddr [PUSH_WIDTH];
  logic [AW-1:0]      w_raddr [POP_WIDTH];

  // Occupancy and free space come only from registered pointers, so the
  // handshake outputs never depend combinationally on push/pop inputs.
  assign w_count = r_wptr - r_rptr;
  assign w_free  = DEPTH_P - w_count;

  // Flush and reset cancel any request presented in the same cycle
  assign w_push_req = fetch_decode_fifo_push & ~fetch_decode_fifo_flush & ~rst;
  assign w_pop_req  = ~fetch_decode_fifo_flush & ~rst;

  // Count how many slots are being written and consumed this cycle
  always_comb begin
    w_push_cnt = '0;
    w_pop_cnt  = '0;
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      w_push_cnt = w_push_cnt + PW'(fetch_decode_fifo_data_in_valid[i]);
    end
    for (int j = 0; j < POP_WIDTH; j++) begin
      w_pop_cnt = w_pop_cnt + PW'(fetch_decode_fifo_pop[j]);
    end
  end

`ifdef FETCH_DECODE_QUEUE_CHECK_EN
  logic w_push_prefix;
  logic w_push_fits;
  logic w_pop_prefix;
  logic w_pop_fits;
  logic w_push_legal;
  logic w_pop_legal;
  logic r_error;

  // A prefix mask has no zero below a one: v & (v + 1) is zero exactly then
  assign w_push_prefix = ((fetch_decode_fifo_data_in_valid &
                           (fetch_decode_fifo_data_in_valid + PUSH_WIDTH'(1))) == '0);
  assign w_push_fits   = ((fetch_decode_fifo_data_in_valid &
                           ~fetch_decode_fifo_data_in_enable) == '0);
  assign w_pop_prefix  = ((fetch_decode_fifo_pop &
                           (fetch_decode_fifo_pop + POP_WIDTH'(1))) == '0);
  assign w_pop_fits    = ((fetch_decode_fifo_pop &
                           ~fetch_decode_fifo_data_out_valid) == '0);

  assign w_push_legal = w_push_prefix & w_push_fits;
  assign w_pop_legal  = w_pop_prefix & w_pop_fits;

  // Illegal requests are dropped whole rather than partially applied
  assign w_push_ok = w_push_req & w_push_legal;
  assign w_pop_ok  = w_pop_req & w_pop_legal;

  // Sticky protocol error; flush cycles are exempt from checking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (!fetch_decode_fifo_flush &&
                 ((fetch_decode_fifo_push && !w_push_legal) || !w_pop_legal)) begin
      r_error <= 1'b1;
    end
  end

  assign fetch_decode_fifo_error = r_error;
`else
  // Without checking the requester is trusted to stay within bounds
  assign w_push_ok = w_push_req;
  assign w_pop_ok  = w_pop_req;
  assign fetch_decode_fifo_error = 1'b0;
`endif

  // Per-slot write and read addresses, wrapping modulo DEPTH
  generate
    for (genvar gi = 0; gi < PUSH_WIDTH; gi++) begin : g_waddr
      logic [PW-1:0] w_wsum;
      assign w_wsum       = r_wptr + PW'(gi);
      assign w_waddr[gi]  = w_wsum[AW-1:0];
    end
    for (genvar gi = 0; gi < POP_WIDTH; gi++) begin : g_raddr
      logic [PW-1:0] w_rsum;
      assign w_rsum       = r_rptr + PW'(gi);
      assign w_raddr[gi]  = w_rsum[AW-1:0];
    end
  endgenerate

  // Storage write: valid input slot i lands i entries past the write pointer
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      for (int i = 0; i < PUSH_WIDTH; i++) begin
        if (fetch_decode_fifo_data_in_valid[i]) begin
          r_mem[w_waddr[i]] <= fetch_decode_fifo_data_in[i];
        end
      end
    end
  end

  // Pointer update; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (rst || fetch_decode_fifo_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + w_push_cnt;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + w_pop_cnt;
      end
    end
  end

  // Free-space advertisement: slot i is offered while more than i entries are free
  generate
    for (genvar gi = 0; gi < PUSH_WIDTH; gi++) begin : g_in_enable
      assign fetch_decode_fifo_data_in_enable[gi] = ~rst & (w_free > PW'(gi));
    end
  endgenerate

  // Oldest entries presented combinationally; slot j valid while more than j are held
  generate
    for (genvar gi = 0; gi < POP_WIDTH; gi++) begin : g_out
      assign fetch_decode_fifo_data_out[gi]       = r_mem[w_raddr[gi]];
      assign fetch_decode_fifo_data_out_valid[gi] = ~rst & (w_count > PW'(gi));
    end
  endgenerate

  assign fetch_decode_fifo_full = ~rst & (w_count == DEPTH_P);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue (DEPTH=16, PUSH=4, POP=2).
// A queue-based reference model tracks the expected contents; every cycle all
// outputs are compared against it one cycle-step at a time.
module tb_fetch_decode_queue;
  localparam int DEPTH = 16;
  localparam int PWID  = 4;
  localparam int QWID  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [PWID-1:0]       en;
  logic [0:PWID-1][63:0] din;
  logic [PWID-1:0]       vin;
  logic                  push;
  logic                  flush;
  logic [0:QWID-1][63:0] dout;
  logic [QWID-1:0]       vout;
  logic [QWID-1:0]       pop;
  logic                  full;
  logic                  err;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mq[$];
  logic        m_err;
  logic [31:0] next_pc;

  always #5 clk = ~clk;

  fetch_decode_queue #(
    .DEPTH      (DEPTH),
    .PUSH_WIDTH (PWID),
    .POP_WIDTH  (QWID)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .fetch_decode_fifo_data_in_enable (en),
    .fetch_decode_fifo_data_in        (din),
    .fetch_decode_fifo_data_in_valid  (vin),
    .fetch_decode_fifo_push           (push),
    .fetch_decode_fifo_flush          (flush),
    .fetch_decode_fifo_data_out       (dout),
    .fetch_decode_fifo_data_out_valid (vout),
    .fetch_decode_fifo_pop            (pop),
    .fetch_decode_fifo_full           (full),
    .fetch_decode_fifo_error          (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model says the queue holds
  task automatic check_all(input string tag);
    int          occ;
    logic [63:0] exp_en;
    logic [63:0] exp_vo;
    logic [63:0] exp_full;
    occ      = mq.size();
    exp_en   = '0;
    exp_vo   = '0;
    exp_full = '0;
    if (!rst) begin
      for (int i = 0; i < PWID; i++) exp_en[i] = ((DEPTH - occ) > i);
      for (int j = 0; j < QWID; j++) exp_vo[j] = (occ > j);
      exp_full[0] = (occ == DEPTH);
    end
    chk({tag, ":in_enable"}, 64'(en), exp_en);
    chk({tag, ":out_valid"}, 64'(vout), exp_vo);
    chk({tag, ":full"}, 64'(full), exp_full);
    chk({tag, ":error"}, 64'(err), 64'(m_err));
    for (int j = 0; j < QWID; j++) begin
      if (!rst && j < occ) chk($sformatf("%s:data%0d", tag, j), dout[j], mq[j]);
    end
    $display("cycle %s occ=%0d push=%b valid=%b pop=%b flush=%b", tag, occ, push, vin, pop, flush);
  endtask

  // Advance one clock, apply the queue rules to the model, then check
  task automatic cycle(input string tag);
    int              occ;
    int              npush;
    int              npop;
    logic [PWID-1:0] pmask;
    logic [QWID-1:0] qmask;
    bit              legal_push;
    bit              legal_pop;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      occ        = mq.size();
      npush      = $countones(vin);
      npop       = $countones(pop);
      pmask      = PWID'((1 << npush) - 1);
      qmask      = QWID'((1 << npop) - 1);
      legal_push = (vin == pmask) && (npush <= DEPTH - occ);
      legal_pop  = (pop == qmask) && (npop <= occ);
`ifdef FETCH_DECODE_QUEUE_CHECK_EN
      if ((push && !legal_push) || !legal_pop) m_err = 1'b1;
`endif
      if (legal_pop) begin
        for (int k = 0; k < npop; k++) void'(mq.pop_front());
      end
      if (push && legal_push) begin
        for (int k = 0; k < npush; k++) mq.push_back(din[k]);
      end
    end
    #1;
    check_all(tag);
  endtask

  // Present n fresh entries (prefix mask), a pop mask and flush, for one cycle
  task automatic drive(input string tag, input int n, input logic [QWID-1:0] p, input bit fl);
    for (int i = 0; i < PWID; i++) begin
      din[i] = {$urandom(), $urandom()};
      if (i < n) begin
        din[i][63:32] = next_pc;
        next_pc       = next_pc + 32'd4;
      end
    end
    vin   = PWID'((1 << n) - 1);
    push  = (n > 0);
    pop   = p;
    flush = fl;
    cycle(tag);
  endtask

  initial begin
    rst     = 1'b1;
    push    = 1'b0;
    flush   = 1'b0;
    pop     = '0;
    vin     = '0;
    din     = '0;
    m_err   = 1'b0;
    next_pc = 32'h8000_0000;

    cycle("reset0");
    cycle("reset1");
    rst = 1'b0;
    drive("idle", 0, 2'b00, 1'b0);

    // First push becomes visible the following cycle, oldest first
    drive("push4", 4, 2'b00, 1'b0);
    chk("first_pc0", 64'(dout[0][63:32]), 64'h8000_0000);
    chk("first_pc1", 64'(dout[1][63:32]), 64'h8000_0004);

    // Fill to DEPTH, then free two slots
    drive("fill1", 4, 2'b00, 1'b0);
    drive("fill2", 4, 2'b00, 1'b0);
    drive("fill3", 4, 2'b00, 1'b0);
    chk("full_set", 64'(full), 64'd1);
    drive("pop2", 0, 2'b11, 1'b0);
    chk("en_after_pop", 64'(en), 64'h3);

    // Push into the only two free slots while popping two
    drive("push2pop2", 2, 2'b11, 1'b0);

    // Random legal traffic crosses the wrap point many times
    for (int c = 0; c < 400; c++) begin
      int occ;
      int maxp;
      int maxq;
      int np;
      int nq;
      occ  = mq.size();
      maxp = (DEPTH - occ < PWID) ? DEPTH - occ : PWID;
      maxq = (occ < QWID) ? occ : QWID;
      np   = $urandom_range(maxp, 0);
      nq   = $urandom_range(maxq, 0);
      drive("rand", np, QWID'((1 << nq) - 1), ($urandom_range(39, 0) == 0));
    end

    // Flush with a simultaneous push and pop at occupancy 10
    drive("pre_flush", 0, 2'b00, 1'b1);
    drive("occ4", 4, 2'b00, 1'b0);
    drive("occ8", 4, 2'b00, 1'b0);
    drive("occ10", 2, 2'b00, 1'b0);
    drive("flush", 4, 2'b11, 1'b1);
    chk("flush_empty", 64'(vout), 64'h0);
    drive("post_flush", 1, 2'b00, 1'b0);
    chk("post_flush_pc", 64'(dout[0][63:32]), 64'(next_pc - 32'd4));

    // Reset mid-operation behaves like flush
    drive("refill", 4, 2'b00, 1'b0);
    rst = 1'b1;
    drive("mid_reset", 4, 2'b01, 1'b0);
    rst = 1'b0;
    drive("after_reset", 0, 2'b00, 1'b0);

`ifdef FETCH_DECODE_QUEUE_CHECK_EN
    // Non-prefix pop at occupancy 3 is dropped and latches the error
    drive("occ3", 3, 2'b00, 1'b0);
    drive("bad_pop", 0, 2'b10, 1'b0);
    chk("bad_pop_err", 64'(err), 64'd1);
    chk("bad_pop_kept", 64'(dout[0][63:32]), 64'(next_pc - 32'd12));
    drive("err_hold1", 0, 2'b01, 1'b0);
    drive("err_hold2", 0, 2'b00, 1'b1);
    rst = 1'b1;
    drive("err_reset", 0, 2'b00, 1'b0);
    rst = 1'b0;
    drive("err_cleared", 0, 2'b00, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
